tmr_unit: RTL and testbench
===========================

Name: tmr_unit

Overview:
- Hardware timer on the far side of the datapath's timer interface.
- Consumes the control word the register file drives on tmr_ctrl.
- Returns the live count on tmr_cntr and the overflow flag on tmr_overflow.
- Up-counter with a power-of-two prescaler, programmable TOP value, one-shot/periodic modes and an edge-triggered overflow acknowledge.

Parameters:
- CNT_W, 16: counter width. Must equal the width of tmr_cntr and of the ctrl[31:16] TOP field.
- PSC_W, 4: width of the prescaler-select field. Divide ratio is 2^PSC, so ratios run from 1 to 2^(2^PSC_W - 1).

Ports:
- clk, input, 1: system clock. Every state element updates on its rising edge.
- reset, input, 1: synchronous, active-high reset.
- tmr_ctrl, input, 32: control word. Fields:
  - [0] EN
  - [1] MODE (0 = one-shot, 1 = periodic)
  - [2] ACK
  - [7:4] PSC
  - [15:8] DUTY (used only by the optional feature)
  - [31:16] TOP
  - [3] is reserved and ignored.
- tmr_cntr, output, CNT_W: current count value, registered.
- tmr_overflow, output, 1: sticky overflow flag, registered.
- pwm_out, output, 1: PWM output. Present only when TMR_PWM_EN is defined.

Behaviour:
- Reset:
  - state = IDLE
  - tmr_cntr = 0
  - tmr_overflow = 0
  - prescaler count = 0
  - ACK history register = 0
  - pwm_out = 0
  - Reset has priority over every other event, including mid-count.
- tmr_ctrl is sampled every edge, with no internal shadow copy. TOP and PSC changes take effect on the next edge.
- States:
  - IDLE:
    - Counter holds its value; prescaler is held at 0.
    - EN=1 -> RUN on this edge. No count occurs on the entry edge.
  - RUN:
    - EN=0 -> IDLE. Counter holds, prescaler clears.
    - Otherwise the prescaler increments each edge.
    - tick = (psc_cnt == 2^PSC - 1). On tick the prescaler wraps to 0.
    - On tick with tmr_cntr < TOP: tmr_cntr <- tmr_cntr + 1.
    - On tick with tmr_cntr >= TOP: tmr_cntr <- 0 and tmr_overflow <- 1.
      - Then MODE=1 keeps RUN; MODE=0 moves to DONE.
      - MODE is evaluated only at the overflow tick.
    - The >= compare means a TOP lowered below the current count overflows on the next tick, with no 2^CNT_W wrap-around.
  - DONE:
    - Counter held at 0; prescaler held at 0.
    - EN=0 -> IDLE. Re-asserting EN restarts counting from 0.
- Period: (TOP+1) ticks = (TOP+1)*2^PSC cycles.
  - TOP=0 overflows on every tick.
  - With PSC=0, a tick occurs on every RUN cycle.
- Latency: EN set before edge 0 gives RUN after edge 0, tmr_cntr=1 after edge 1, tmr_cntr=k after edge k (PSC=0).
- ACK:
  - ack_rise = ACK & ~ack_q; ack_q <- ACK every edge.
  - ack_rise clears tmr_overflow in any state.
  - If ack_rise coincides with an overflow tick, the set wins and the flag stays 1.
  - A held-high ACK clears the flag only once.
- The PSC change boundary is not special-cased: a smaller ratio with psc_cnt already past the new terminal value runs until the prescaler wraps at 2^(2^PSC_W) (intentional, documented).

Optional Feature:
- Macro: TMR_PWM_EN.
- Defined:
  - pwm_out port exists and is registered.
  - pwm_out <- (state==RUN) & (tmr_cntr < {DUTY, zero-extended to CNT_W}).
  - DUTY=0 gives constant 0. Outside RUN, pwm_out = 0.
- Undefined: port absent. No DUTY logic is generated; ctrl[15:8] is ignored.

Decomposition:
- Shared include file (alongside the register definitions) holds:
  - ctrl bit positions: TMR_EN_BIT=0, TMR_MODE_BIT=1, TMR_ACK_BIT=2, TMR_PSC_LSB=4, TMR_DUTY_LSB=8, TMR_TOP_LSB=16
  - state encodings: TMR_IDLE=2'd0, TMR_RUN=2'd1, TMR_DONE=2'd2
- Sub-module tmr_prescaler:
  - Inputs: clk, reset, run, psc.
  - Output: tick.
  - Owns psc_cnt and its clear-when-not-run behaviour.

Test Plan:
- Periodic count: reset, then ctrl = TOP=3, PSC=0, MODE=1, EN=1 -> tmr_cntr is 1,2,3,0,1 after edges 1-5. tmr_overflow rises after edge 4 and stays 1.
- Prescaler: TOP=1, PSC=2, MODE=1, EN=1 -> tmr_cntr steps every 4 cycles (0,1,0). First overflow after edge 8.
- One-shot: TOP=2, MODE=0, EN=1 -> overflow after edge 3, state DONE, tmr_cntr held 0 for 10 cycles. Toggling EN 0->1 restarts, and the next overflow comes 3 ticks after re-entry.
- ACK edge/priority:
  - Raise ACK while tmr_overflow=1 -> cleared next edge.
  - Holding ACK high through a later overflow -> flag set and stays set.
  - ACK rise timed on an overflow tick -> flag remains 1.
- Mid-run events:
  - At tmr_cntr=40 with TOP=100, write TOP=10 -> tmr_cntr=0 and overflow=1 on the next tick.
  - Drop EN at tmr_cntr=5 -> holds 5; re-enable resumes at 6.
  - Assert reset at tmr_cntr=7 -> all outputs 0 on the next edge.
- TMR_PWM_EN: TOP=9, DUTY=3, PSC=0 -> pwm_out is high for exactly 3 of every 10 cycles while RUN, and 0 in IDLE.

Source files
------------

// File: rtl/tmr_unit_pkg.sv
// Shared definitions for the timer: control-word bit positions and FSM state encodings.
// Included by tmr_unit and tmr_prescaler; the TMR_PWM_EN macro is interpreted in tmr_unit.
package tmr_unit_pkg;

  localparam int TMR_EN_BIT   = 0;
  localparam int TMR_MODE_BIT = 1;
  localparam int TMR_ACK_BIT  = 2;
  localparam int TMR_PSC_LSB  = 4;
  localparam int TMR_DUTY_LSB = 8;
  localparam int TMR_TOP_LSB  = 16;

  localparam int TMR_DUTY_W   = 8;

  typedef enum logic [1:0] {
    TMR_IDLE = 2'd0,
    TMR_RUN  = 2'd1,
    TMR_DONE = 2'd2
  } tmr_state_e;

endpackage

// File: rtl/tmr_unit_prescaler.sv
// Power-of-two prescaler: pulses tick once every 2^psc enabled cycles, cleared when not running.
module tmr_prescaler
  import tmr_unit_pkg::*;
#(
  parameter int PSC_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [PSC_W-1:0] psc,
  output logic             tick
);

  // Wide enough to hold the largest terminal value 2^(2^PSC_W - 1) - 1.
  localparam int PCNT_W = 2 ** PSC_W;

  logic [PCNT_W-1:0] psc_cnt_q;
  logic [PCNT_W-1:0] psc_cnt_d;
  logic [PCNT_W-1:0] term;

  always_comb begin
    term      = (PCNT_W'(1) << psc) - PCNT_W'(1);
    tick      = run && (psc_cnt_q == term);
    psc_cnt_d = '0;
    if (run && !tick) begin
      psc_cnt_d = psc_cnt_q + PCNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      psc_cnt_q <= '0;
    end else begin
      psc_cnt_q <= psc_cnt_d;
    end
  end

endmodule

// File: rtl/tmr_unit.sv
// Timer unit: prescaled up-counter with programmable TOP, one-shot/periodic modes and sticky overflow.
// Optional PWM output is built when TMR_PWM_EN is defined.
module tmr_unit
  import tmr_unit_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int PSC_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      tmr_ctrl,
  output logic [CNT_W-1:0] tmr_cntr,
  output logic             tmr_overflow
`ifdef TMR_PWM_EN
  ,
  output logic             pwm_out
`endif
);

  tmr_state_e       state_q, state_d;
  logic [CNT_W-1:0] cntr_q, cntr_d;
  logic             ovf_q, ovf_d;
  logic             ack_q;

  logic             en, mode, ack, ack_rise, run, tick;
  logic [PSC_W-1:0] psc;
  logic [CNT_W-1:0] top;

  assign en   = tmr_ctrl[TMR_EN_BIT];
  assign mode = tmr_ctrl[TMR_MODE_BIT];
  assign ack  = tmr_ctrl[TMR_ACK_BIT];
  assign psc  = tmr_ctrl[TMR_PSC_LSB +: PSC_W];
  assign top  = tmr_ctrl[TMR_TOP_LSB +: CNT_W];

  assign ack_rise = ack && !ack_q;
  assign run      = (state_q == TMR_RUN) && en;

  tmr_prescaler #(.PSC_W(PSC_W)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .run   (run),
    .psc   (psc),
    .tick  (tick)
  );

  // The ack clear is applied first so a same-edge overflow set overrides it.
  always_comb begin
    state_d = state_q;
    cntr_d  = cntr_q;
    ovf_d   = ovf_q;
    if (ack_rise) begin
      ovf_d = 1'b0;
    end
    case (state_q)
      TMR_IDLE: begin
        if (en) begin
          state_d = TMR_RUN;
        end
      end
      TMR_RUN: begin
        if (!en) begin
          state_d = TMR_IDLE;
        end else if (tick) begin
          if (cntr_q < top) begin
            cntr_d = cntr_q + CNT_W'(1);
          end else begin
            cntr_d = '0;
            ovf_d  = 1'b1;
            if (!mode) begin
              state_d = TMR_DONE;
            end
          end
        end
      end
      TMR_DONE: begin
        cntr_d = '0;
        if (!en) begin
          state_d = TMR_IDLE;
        end
      end
      default: begin
        state_d = TMR_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= TMR_IDLE;
      cntr_q  <= '0;
      ovf_q   <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cntr_q  <= cntr_d;
      ovf_q   <= ovf_d;
      ack_q   <= ack;
    end
  end

  assign tmr_cntr     = cntr_q;
  assign tmr_overflow = ovf_q;

`ifdef TMR_PWM_EN
  logic [TMR_DUTY_W-1:0] duty;
  logic                  pwm_q, pwm_d;

  assign duty = tmr_ctrl[TMR_DUTY_LSB +: TMR_DUTY_W];

  always_comb begin
    pwm_d = (state_q == TMR_RUN) && (cntr_q < CNT_W'(duty));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_q <= 1'b0;
    end else begin
      pwm_q <= pwm_d;
    end
  end

  assign pwm_out = pwm_q;

  logic unused_ctrl;
  assign unused_ctrl = tmr_ctrl[3];
`else
  logic unused_ctrl;
  assign unused_ctrl = ^{tmr_ctrl[3], tmr_ctrl[TMR_DUTY_LSB +: TMR_DUTY_W]};
`endif

endmodule

// File: tb/tb_tmr_unit.sv
// Scoreboard bench for tmr_unit: stimulus pushes expected outputs, a negedge monitor pops and compares.
// PWM vectors are included when TMR_PWM_EN is defined.
module tb_tmr_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] tmr_ctrl = 32'd0;
  logic [15:0] tmr_cntr;
  logic        tmr_overflow;
`ifdef TMR_PWM_EN
  logic        pwm_out;
`endif

  typedef struct {
    string       name;
    logic [15:0] cntr;
    logic        ovf;
    logic        chk_pwm;
    logic        pwm;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;

  localparam logic [31:0] ACK = 32'h0000_0004;

  tmr_unit #(.CNT_W(16), .PSC_W(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .tmr_ctrl     (tmr_ctrl),
    .tmr_cntr     (tmr_cntr),
    .tmr_overflow (tmr_overflow)
`ifdef TMR_PWM_EN
    ,
    .pwm_out      (pwm_out)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk_ctrl(input logic en, input logic mode, input logic ack,
                                          input logic [3:0] psc, input logic [7:0] duty,
                                          input logic [15:0] top);
    return {top, duty, psc, 1'b0, ack, mode, en};
  endfunction

  task automatic applyStimulus(input logic [31:0] c, input logic rst);
    reset    = rst;
    tmr_ctrl = c;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string n, input logic [15:0] c, input logic o);
    exp_t e;
    e.name = n; e.cntr = c; e.ovf = o; e.chk_pwm = 1'b0; e.pwm = 1'b0;
    sb_q.push_back(e);
  endtask

  task automatic checkPwm(input string n, input logic [15:0] c, input logic o, input logic p);
    exp_t e;
    e.name = n; e.cntr = c; e.ovf = o; e.chk_pwm = 1'b1; e.pwm = p;
    sb_q.push_back(e);
  endtask

  // Monitor: compare one queued expectation per falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checks++;
        if (tmr_cntr !== e.cntr) begin
          failures++;
          $display("[TB] FAIL %s cntr: got %0d expected %0d", e.name, tmr_cntr, e.cntr);
        end
        checks++;
        if (tmr_overflow !== e.ovf) begin
          failures++;
          $display("[TB] FAIL %s overflow: got %0b expected %0b", e.name, tmr_overflow, e.ovf);
        end
`ifdef TMR_PWM_EN
        if (e.chk_pwm) begin
          checks++;
          if (pwm_out !== e.pwm) begin
            failures++;
            $display("[TB] FAIL %s pwm: got %0b expected %0b", e.name, pwm_out, e.pwm);
          end
        end
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] c;
    int exp_c[5];
    int exp_o[5];
    exp_c = '{1, 2, 3, 0, 1};
    exp_o = '{0, 0, 0, 1, 1};

    applyStimulus(32'd0, 1'b1); checkOutput("reset", 16'd0, 1'b0);
    applyStimulus(32'd0, 1'b1); checkOutput("reset_hold", 16'd0, 1'b0);

    $display("[TB] periodic count TOP=3 PSC=0");
    c = mk_ctrl(1, 1, 0, 4'd0, 8'd0, 16'd3);
    applyStimulus(c, 1'b0); checkOutput("per_entry", 16'd0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(c, 1'b0); checkOutput("per_count", 16'(exp_c[k]), 1'(exp_o[k]));
    end

    $display("[TB] ack edge and priority");
    applyStimulus(c | ACK, 1'b0); checkOutput("ack_clear", 16'd2, 1'b0);
    applyStimulus(c | ACK, 1'b0); checkOutput("ack_hold", 16'd3, 1'b0);
    applyStimulus(c | ACK, 1'b0); checkOutput("ack_held_ovf", 16'd0, 1'b1);
    applyStimulus(c | ACK, 1'b0); checkOutput("ack_held_stay", 16'd1, 1'b1);
    applyStimulus(c, 1'b0);       checkOutput("ack_low", 16'd2, 1'b1);
    applyStimulus(c, 1'b0);       checkOutput("ack_low2", 16'd3, 1'b1);
    applyStimulus(c | ACK, 1'b0); checkOutput("ack_on_tick", 16'd0, 1'b1);
    applyStimulus(c, 1'b0);       checkOutput("ack_after_tick", 16'd1, 1'b1);

    $display("[TB] prescaler TOP=1 PSC=2");
    applyStimulus(32'd0, 1'b1); checkOutput("psc_reset", 16'd0, 1'b0);
    c = mk_ctrl(1, 1, 0, 4'd2, 8'd0, 16'd1);
    applyStimulus(c, 1'b0); checkOutput("psc_entry", 16'd0, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(c, 1'b0);
      checkOutput("psc_count", (k >= 4 && k < 8) ? 16'd1 : 16'd0, (k == 8));
    end

    $display("[TB] one-shot TOP=2");
    applyStimulus(32'd0, 1'b1); checkOutput("os_reset", 16'd0, 1'b0);
    c = mk_ctrl(1, 0, 0, 4'd0, 8'd0, 16'd2);
    applyStimulus(c, 1'b0); checkOutput("os_entry", 16'd0, 1'b0);
    applyStimulus(c, 1'b0); checkOutput("os_count1", 16'd1, 1'b0);
    applyStimulus(c, 1'b0); checkOutput("os_count2", 16'd2, 1'b0);
    applyStimulus(c, 1'b0); checkOutput("os_ovf", 16'd0, 1'b1);
    for (int k = 0; k < 10; k++) begin
      applyStimulus(c, 1'b0); checkOutput("os_done_hold", 16'd0, 1'b1);
    end
    applyStimulus(ACK, 1'b0);     checkOutput("os_idle_ack", 16'd0, 1'b0);
    applyStimulus(c | ACK, 1'b0); checkOutput("os_reentry", 16'd0, 1'b0);
    applyStimulus(c | ACK, 1'b0); checkOutput("os_restart1", 16'd1, 1'b0);
    applyStimulus(c | ACK, 1'b0); checkOutput("os_restart2", 16'd2, 1'b0);
    applyStimulus(c | ACK, 1'b0); checkOutput("os_restart_ovf", 16'd0, 1'b1);
    applyStimulus(c, 1'b0);       checkOutput("os_done_again", 16'd0, 1'b1);

    $display("[TB] mid-run TOP lowering");
    applyStimulus(32'd0, 1'b1); checkOutput("mid_reset", 16'd0, 1'b0);
    c = mk_ctrl(1, 1, 0, 4'd0, 8'd0, 16'd100);
    applyStimulus(c, 1'b0);
    for (int k = 0; k < 40; k++) applyStimulus(c, 1'b0);
    checkOutput("top_at40", 16'd40, 1'b0);
    c = mk_ctrl(1, 1, 0, 4'd0, 8'd0, 16'd10);
    applyStimulus(c, 1'b0); checkOutput("top_lower", 16'd0, 1'b1);

    $display("[TB] EN drop and resume");
    for (int k = 0; k < 5; k++) applyStimulus(c, 1'b0);
    checkOutput("en_at5", 16'd5, 1'b1);
    applyStimulus(mk_ctrl(0, 1, 0, 4'd0, 8'd0, 16'd10), 1'b0); checkOutput("en_drop", 16'd5, 1'b1);
    applyStimulus(mk_ctrl(0, 1, 0, 4'd0, 8'd0, 16'd10), 1'b0); checkOutput("en_idle", 16'd5, 1'b1);
    applyStimulus(c, 1'b0); checkOutput("en_reentry", 16'd5, 1'b1);
    applyStimulus(c, 1'b0); checkOutput("en_resume", 16'd6, 1'b1);
    applyStimulus(c, 1'b0); checkOutput("en_at7", 16'd7, 1'b1);

    $display("[TB] reset mid-count");
    applyStimulus(c, 1'b1); checkOutput("rst_mid", 16'd0, 1'b0);
    applyStimulus(c, 1'b0); checkOutput("rst_release", 16'd0, 1'b0);
    applyStimulus(c, 1'b0); checkOutput("rst_count", 16'd1, 1'b0);

    $display("[TB] TOP=0 boundary");
    applyStimulus(32'd0, 1'b1); checkOutput("top0_reset", 16'd0, 1'b0);
    c = mk_ctrl(1, 1, 0, 4'd0, 8'd0, 16'd0);
    applyStimulus(c, 1'b0); checkOutput("top0_entry", 16'd0, 1'b0);
    applyStimulus(c, 1'b0); checkOutput("top0_tick1", 16'd0, 1'b1);
    applyStimulus(c | ACK, 1'b0); checkOutput("top0_tick2", 16'd0, 1'b1);

`ifdef TMR_PWM_EN
    $display("[TB] pwm TOP=9 DUTY=3");
    applyStimulus(32'd0, 1'b1); checkPwm("pwm_reset", 16'd0, 1'b0, 1'b0);
    c = mk_ctrl(1, 1, 0, 4'd0, 8'd3, 16'd9);
    applyStimulus(c, 1'b0); checkPwm("pwm_entry", 16'd0, 1'b0, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      applyStimulus(c, 1'b0);
      checkPwm("pwm_run", 16'(k % 10), (k >= 10), (((k - 1) % 10) < 3));
    end
    applyStimulus(mk_ctrl(0, 1, 0, 4'd0, 8'd3, 16'd9), 1'b0); checkPwm("pwm_drop", 16'd0, 1'b1, 1'b1);
    applyStimulus(mk_ctrl(0, 1, 0, 4'd0, 8'd3, 16'd9), 1'b0); checkPwm("pwm_idle", 16'd0, 1'b1, 1'b0);
`endif

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain: got %0d pending expectations, required 0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
